apb_uart_master: RTL and testbench

- Single-outstanding APB3 master that sits directly upstream of apb_uart_wrapper.
- Converts a simple valid/ready request interface (from a CPU-side sequencer or host bridge) into APB setup/access phases.
- Returns read data and error status as a one-cycle response pulse.
- Adds local address-range checking and a PREADY-stall timeout so a hung slave never locks the requester.

---
 rtl/apb_uart_pkg.sv | 29 ++
 rtl/apb_wait_timer.sv | 35 +++
 rtl/apb_uart_master.sv | 145 ++++++++++++++
 tb/tb_apb_uart_master.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART master and its helpers.
//   - Register address map of the downstream apb_uart_wrapper.
//   - Master FSM state encoding.
//   - Default bus and timeout widths.
package apb_uart_pkg;

  // Register map
  localparam int unsigned CTRL_REG_ADDR  = 32'h0;
  localparam int unsigned STATS_REG_ADDR = 32'h1;
  localparam int unsigned TX_DATA_ADDR   = 32'h2;
  localparam int unsigned RX_DATA_ADDR   = 32'h3;
  localparam int unsigned BAUDIV_ADDR    = 32'h4;

  // Default widths and limits
  localparam int unsigned DefPaddrWidth   = 32;
  localparam int unsigned DefPwdataWidth  = 32;
  localparam int unsigned DefPrdataWidth  = 32;
  localparam int unsigned DefAddrLimit    = BAUDIV_ADDR;
  localparam int unsigned DefTimeoutCyc   = 16;
  localparam int unsigned DefToCntWidth   = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StDecErr
  } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Stall counter for the APB ACCESS phase.
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   clear  : zero the count (wins over enable)
//   enable : count one stall cycle at this edge
//   expire : this enabled edge brings the count to LIMIT (never when LIMIT = 0)
module apb_wait_timer #(
  parameter int unsigned LIMIT = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [WIDTH-1:0] LimitM1 = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Combinational so the FSM can abort on the same edge the count reaches LIMIT.
  assign expire = (LIMIT != 0) && enable && (cnt_q == LimitM1);

endmodule

// File: rtl/apb_uart_master.sv
// Single-outstanding APB3 master in front of apb_uart_wrapper.
//   PCLK, PRESETn          : clock, asynchronous active-low reset
//   req_valid/ready/write/addr/wdata : request handshake from the host side
//   rsp_valid/rdata/err/timeout      : one-cycle response pulse, no backpressure
//   PADDR..PWDATA (out), PRDATA/PREADY/PSLVERR (in) : APB3 master port
// Addresses above ADDR_LIMIT are answered locally with a decode error; an ACCESS
// phase stalled for TIMEOUT_CYCLES is aborted with rsp_timeout set.
module apb_uart_master
  import apb_uart_pkg::*;
#(
  parameter int unsigned PADDR_WIDTH    = DefPaddrWidth,
  parameter int unsigned PWDATA_WIDTH   = DefPwdataWidth,
  parameter int unsigned PRDATA_WIDTH   = DefPrdataWidth,
  parameter int unsigned ADDR_LIMIT     = DefAddrLimit,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCyc,
  parameter int unsigned TO_CNT_WIDTH   = DefToCntWidth
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [PADDR_WIDTH-1:0]  req_addr,
  input  logic [PWDATA_WIDTH-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic [PRDATA_WIDTH-1:0] rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [PADDR_WIDTH-1:0]  PADDR,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [PWDATA_WIDTH-1:0] PWDATA,
  input  logic [PRDATA_WIDTH-1:0] PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  apb_state_e state_q, state_d;

  logic [PADDR_WIDTH-1:0]  paddr_d;
  logic [PWDATA_WIDTH-1:0] pwdata_d;
  logic                    pwrite_d;
  logic                    rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic [PRDATA_WIDTH-1:0] rsp_rdata_d;
  logic                    timer_clear, timer_en, timer_expire;

  apb_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .WIDTH (TO_CNT_WIDTH)
  ) u_wait_timer (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .clear  (timer_clear),
    .enable (timer_en),
    .expire (timer_expire)
  );

  always_comb begin
    state_d       = state_q;
    paddr_d       = PADDR;
    pwdata_d      = PWDATA;
    pwrite_d      = PWRITE;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;
    timer_clear   = 1'b0;
    timer_en      = 1'b0;

    case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          paddr_d  = req_addr;
          pwdata_d = req_wdata;
          pwrite_d = req_write;
          if (req_addr > PADDR_WIDTH'(ADDR_LIMIT)) begin
            state_d = StDecErr;
          end else begin
            state_d     = StSetup;
            timer_clear = 1'b1;
          end
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        // Completion has priority over a timeout reached on the same edge.
        if (PREADY) begin
          state_d       = StIdle;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = PWRITE ? '0 : PRDATA;
        end else begin
          timer_en = 1'b1;
          if (timer_expire) begin
            state_d       = StIdle;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = '0;
          end
        end
      end
      StDecErr: begin
        state_d       = StIdle;
        rsp_valid_d   = 1'b1;
        rsp_err_d     = 1'b1;
        rsp_timeout_d = 1'b0;
        rsp_rdata_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Every output is registered from the next state so it changes only at PCLK edges.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= StIdle;
      req_ready   <= 1'b1;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready   <= (state_d == StIdle);
      PSEL        <= (state_d == StSetup) || (state_d == StAccess);
      PENABLE     <= (state_d == StAccess);
      PADDR       <= paddr_d;
      PWDATA      <= pwdata_d;
      PWRITE      <= pwrite_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_apb_uart_master.sv
// Self-checking bench for apb_uart_master: directed steps followed by random
// transfers, with the bench acting as the APB slave.
module tb_apb_uart_master;
  import apb_uart_pkg::*;

  localparam int unsigned Limit    = 4;
  localparam int unsigned ToCycles = 16;
  localparam int          Never    = 1000;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  int total = 0;
  int bad = 0;

  apb_uart_master dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PADDR       (PADDR),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int          lat;    // negedges after the accept edge until rsp_valid is seen
    int          acc;    // ACCESS cycles seen on the bus
    logic        apb;    // request reaches the APB bus at all
    logic        err;
    logic        to;
    logic [31:0] rdata;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  // Reference: what the requester should see for one transfer whose slave
  // raises PREADY after `waits` wait states.
  function automatic exp_t model(input logic wr, input logic [31:0] addr, input int waits,
                                 input logic [31:0] prd, input logic slverr);
    exp_t e;
    if (addr > Limit) begin
      e.apb = 1'b0; e.acc = 0; e.lat = 1;
      e.err = 1'b1; e.to = 1'b0; e.rdata = '0;
    end else if (ToCycles != 0 && waits >= int'(ToCycles)) begin
      e.apb = 1'b1; e.acc = ToCycles; e.lat = 1 + ToCycles;
      e.err = 1'b1; e.to = 1'b1; e.rdata = '0;
    end else begin
      e.apb = 1'b1; e.acc = waits + 1; e.lat = 1 + e.acc;
      e.err = slverr; e.to = 1'b0; e.rdata = wr ? 32'h0 : prd;
    end
    return e;
  endfunction

  // Called at a negedge; the request is accepted on the following posedge.
  task automatic start_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input bit hold);
    int n = 0;
    while (req_ready !== 1'b1 && n < 40) begin
      @(negedge PCLK);
      n++;
    end
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge PCLK);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  // Plays the slave and checks the transfer; returns at the negedge that sees rsp_valid.
  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input logic [31:0] prd, input logic slverr,
                          output exp_t e);
    int acc = 0;
    int psel_cycles = 0;
    bit seen = 0;
    bit stable = 1;
    e = model(wr, addr, waits, prd, slverr);
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge PCLK);
      if (rsp_valid === 1'b1) begin
        seen = 1;
        check("rsp_latency", k, e.lat);
        check("rsp_err", rsp_err, e.err);
        check("rsp_timeout", rsp_timeout, e.to);
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_psel_low", {PSEL, PENABLE}, 2'b00);
        check("rsp_req_ready", req_ready, 1'b1);
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
      end else begin
        if (k == 0 && e.apb) begin
          check("setup_psel_penable", {PSEL, PENABLE}, 2'b10);
          check("setup_paddr", PADDR, addr);
          check("setup_pwdata", PWDATA, wdata);
          check("setup_pwrite", PWRITE, wr);
        end
        if (PSEL === 1'b1) psel_cycles++;
        if (PSEL === 1'b1 && PENABLE === 1'b1) begin
          if (PADDR !== addr || PWRITE !== wr || PWDATA !== wdata) stable = 0;
          PREADY  = (acc == waits);
          PRDATA  = (acc == waits) ? prd : $urandom();
          PSLVERR = (acc == waits) ? slverr : 1'($urandom_range(0, 1));
          acc++;
        end else begin
          PREADY = 1'b0;
        end
      end
    end
    check("rsp_seen", seen, 1'b1);
    check("access_cycles", acc, e.acc);
    check("psel_cycles", psel_cycles, e.apb ? e.acc + 1 : 0);
    check("apb_stable", stable, 1'b1);
  endtask

  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] prd, input logic slverr);
    exp_t e;
    start_req(wr, addr, wdata, 1'b0);
    run_xfer(wr, addr, wdata, waits, prd, slverr, e);
    @(negedge PCLK);
    check("rsp_pulse_end", rsp_valid, 1'b0);
    check("rsp_rdata_hold", rsp_rdata, e.rdata);
    check("rsp_err_hold", rsp_err, e.err);
    check("rsp_timeout_hold", rsp_timeout, e.to);
  endtask

  initial begin
    exp_t e;
    int cnt;

    // Reset values
    @(negedge PCLK);
    @(negedge PCLK);
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_apb_ctrl", {PSEL, PENABLE, PWRITE}, 3'b000);
    check("reset_paddr", PADDR, 32'h0);
    check("reset_pwdata", PWDATA, 32'h0);
    check("reset_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // Directed transfers
    do_xfer(1'b1, TX_DATA_ADDR, 32'h55, 0, 32'h0, 1'b0);
    do_xfer(1'b0, RX_DATA_ADDR, 32'h0, 2, 32'hAF, 1'b0);
    do_xfer(1'b0, 32'h7, 32'h0, 0, 32'h0, 1'b0);
    do_xfer(1'b0, STATS_REG_ADDR, 32'h0, Never, 32'hDEAD_BEEF, 1'b0);
    do_xfer(1'b0, RX_DATA_ADDR, 32'h0, ToCycles - 1, 32'h1234_5678, 1'b0);
    do_xfer(1'b0, RX_DATA_ADDR, 32'h0, ToCycles, 32'h1234_5678, 1'b0);
    do_xfer(1'b0, BAUDIV_ADDR, 32'h0, 0, 32'h0000_00C3, 1'b0);
    do_xfer(1'b1, 32'h5, 32'hFFFF, 0, 32'h0, 1'b0);

    // PSLVERR write, with a second request held valid throughout
    start_req(1'b1, CTRL_REG_ADDR, 32'h1, 1'b1);
    req_write = 1'b0;
    req_addr  = BAUDIV_ADDR;
    run_xfer(1'b1, CTRL_REG_ADDR, 32'h1, 0, 32'h0, 1'b1, e);
    check("b2b_valid_held", req_valid, 1'b1);
    @(posedge PCLK);
    #1;
    req_valid = 1'b0;
    run_xfer(1'b0, BAUDIV_ADDR, 32'h1, 1, 32'h0000_0042, 1'b0, e);
    @(negedge PCLK);
    check("b2b_pulse_end", rsp_valid, 1'b0);

    // Reset in the middle of an ACCESS phase
    start_req(1'b0, STATS_REG_ADDR, 32'h0, 1'b0);
    PREADY = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    check("pre_reset_access", {PSEL, PENABLE}, 2'b11);
    #2;
    PRESETn = 1'b0;
    #1;
    check("async_reset_apb", {PSEL, PENABLE}, 2'b00);
    check("async_reset_rsp", rsp_valid, 1'b0);
    check("async_reset_ready", req_ready, 1'b1);
    @(negedge PCLK);
    PRESETn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (rsp_valid !== 1'b0 || PSEL !== 1'b0) cnt++;
    end
    check("no_rsp_after_reset", cnt, 0);
    do_xfer(1'b1, TX_DATA_ADDR, 32'hA5, 1, 32'h0, 1'b0);

    // Random transfers
    for (int i = 0; i < 25; i++) begin
      logic        wr;
      logic [31:0] addr, wdata, prd;
      logic        slv;
      int          waits;
      wr    = 1'($urandom_range(0, 1));
      addr  = $urandom_range(0, 7);
      wdata = $urandom();
      prd   = $urandom();
      slv   = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0:       waits = ToCycles - 1;
        1:       waits = ToCycles + 3;
        default: waits = $urandom_range(0, 3);
      endcase
      do_xfer(wr, addr, wdata, waits, prd, slv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
